pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Pipeline sequencer for the 4-stage core: ID -> EX -> MEM -> WB.
- Consumes the decoder's per-instruction control fields in ID.
- Tracks in-flight destinations in a small scoreboard.
- Generates stall, bubble and flush controls for load-use hazards, memory wait states, EX-stage redirects and halt drain.
- Sits between the decoder and the IF/ID and ID/EX pipeline registers.

Parameters:
- DRAIN_CYCLES, 3: cycles spent draining EX/MEM/WB after a halt issues, before `halted` rises.
- REG_W, 5: register-address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- src1_reg  in  REG_W  decoder source 1
- src2_reg  in  REG_W  decoder source 2
- dst_reg  in  REG_W  decoder destination
- alu_op1_type  in  2  decoder op1 type; src1 is used iff it equals `OP_TYPE_REG
- alu_op2_type  in  2  decoder op2 type; src2 is used iff it equals `OP_TYPE_REG, or when is_store=1
- reg_w_enable  in  1  decoder write enable
- is_load  in  1  decoder load flag
- is_store  in  1  decoder store flag
- is_halt  in  1  decoder halt flag
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- mem_ready  in  1  data memory completes the MEM-stage access this cycle
- if_stall  out  1  hold PC and the IF/ID register
- id_stall  out  1  hold the ID instruction (do not advance)
- ex_bubble  out  1  load a NOP into ID/EX
- if_id_flush  out  1  invalidate the IF/ID register
- mem_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_req  out  1  MEM stage holds a load/store
- halted  out  1  core halted; sticky until rst

Behaviour:
- Scoreboard registers:
  - EX slot: {v, dst, wen, ld, st}.
  - MEM slot: {v, dst, wen, ld, st}.
  - Reset clears both slots.
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Outputs are combinational from the state, scoreboard and inputs. All outputs are 0 in the reset state when inputs are idle.
- mem_req = MEM.v & (MEM.ld | MEM.st).
- mem_freeze = mem_req & ~mem_ready. When mem_freeze=1: if_stall=1, id_stall=1, ex_bubble=0, and no scoreboard update. Freeze overrides every other condition except rst.
- Load-use hazard (lu):
  - Condition: id_valid & EX.v & EX.ld & EX.wen & EX.dst != 0 & ((src1 used & src1_reg == EX.dst) | (src2 used & src2_reg == EX.dst)).
  - Response: if_stall=1, id_stall=1, ex_bubble=1 for exactly 1 cycle. Matches against MEM.dst do not stall; forwarding covers them.
- Redirect:
  - ex_redirect & ~mem_freeze gives if_id_flush=1 and ex_bubble=1.
  - The ID instruction is discarded and lu is ignored that cycle.
  - Redirect has priority over lu and over halt.
- Issue = state==RUN & id_valid & ~mem_freeze & ~lu & ~ex_redirect.
- On each non-frozen edge:
  - EX slot <= issue ? {1, dst_reg, reg_w_enable & dst_reg != 0, is_load, is_store} : 0.
  - MEM slot <= EX slot.
- Halt:
  - Issue with is_halt=1: the halt itself enters EX as a bubble (v=0), the counter loads DRAIN_CYCLES, and the FSM goes to DRAIN.
- DRAIN:
  - if_stall=1, id_stall=1, ex_bubble=1.
  - The counter decrements on non-frozen cycles only.
  - At 0 the FSM goes to HALTED.
  - ex_redirect during DRAIN is ignored; no younger instruction exists.
- HALTED: halted=1, if_stall=1, id_stall=1, ex_bubble=1 until rst.
- rst mid-operation: the next cycle is the full reset state (RUN, slots cleared, counter 0), regardless of freeze or drain.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- When defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each cycle with (lu | mem_freeze) & state==RUN.
  - flush_cnt increments on each cycle with if_id_flush=1.
  - Both clear on rst and wrap at 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use hazard: issue lw x5 (is_load=1, dst=5), next cycle addi src1=5 (op1 REG) -> that cycle if_stall=id_stall=ex_bubble=1; next cycle issue with no stall. Same sequence with dst=0 -> no stall.
- Store data hazard: lw x7 then sw src2=7 (is_store=1, op2 IMM) -> 1-cycle stall. lw x7 then lui (op1 NONE, src1=7) -> no stall.
- Memory wait: lw in MEM with mem_ready=0 for 3 cycles -> mem_freeze=1 and mem_req=1 for 3 cycles, scoreboard held; mem_ready=1 -> pipeline advances. A lu condition during the freeze shows ex_bubble=0.
- Redirect: ex_redirect=1 while ID holds a load-use-hazard instruction -> if_id_flush=1, ex_bubble=1, no stall, EX slot empty next cycle.
- Halt drain: issue is_halt with DRAIN_CYCLES=3 -> halted rises exactly 4 cycles after the issue edge, if_stall held throughout. Insert 2 freeze cycles during DRAIN -> halted rises 2 cycles later. rst then clears halted in 1 cycle.
- Perf counters (with PIPELINE_CTRL_PERF_EN): 1 lu stall + 3 freeze cycles + 1 redirect -> stall_cnt=4, flush_cnt=1.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Decoder/hazard-control bundle between ID and the pipeline sequencer.
// PIPELINE_CTRL_PERF_EN adds the stall/flush counter outputs.
`ifndef OP_TYPE_NONE
`define OP_TYPE_NONE 2'b00
`endif
`ifndef OP_TYPE_REG
`define OP_TYPE_REG 2'b01
`endif
`ifndef OP_TYPE_IMM
`define OP_TYPE_IMM 2'b10
`endif

interface pipeline_ctrl_if #(
  parameter int REG_W = 5
) ();
  logic             id_valid;
  logic [REG_W-1:0] src1_reg;
  logic [REG_W-1:0] src2_reg;
  logic [REG_W-1:0] dst_reg;
  logic [1:0]       alu_op1_type;
  logic [1:0]       alu_op2_type;
  logic             reg_w_enable;
  logic             is_load;
  logic             is_store;
  logic             is_halt;
  logic             ex_redirect;
  logic             mem_ready;
  logic             if_stall;
  logic             id_stall;
  logic             ex_bubble;
  logic             if_id_flush;
  logic             mem_freeze;
  logic             mem_req;
  logic             halted;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
`endif

  modport master (
    output id_valid, src1_reg, src2_reg, dst_reg,
    output alu_op1_type, alu_op2_type,
    output reg_w_enable, is_load, is_store, is_halt,
    output ex_redirect, mem_ready,
    input  if_stall, id_stall, ex_bubble,
    input  if_id_flush, mem_freeze, mem_req, halted
`ifdef PIPELINE_CTRL_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, src1_reg, src2_reg, dst_reg,
    input  alu_op1_type, alu_op2_type,
    input  reg_w_enable, is_load, is_store, is_halt,
    input  ex_redirect, mem_ready,
    output if_stall, id_stall, ex_bubble,
    output if_id_flush, mem_freeze, mem_req, halted
`ifdef PIPELINE_CTRL_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// ID->EX->MEM->WB sequencer: scoreboard, stall/bubble/flush and halt drain.
// Optional PIPELINE_CTRL_PERF_EN adds stall_cnt/flush_cnt.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_W        = 5
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             wen;
    logic             ld;
    logic             st;
  } slot_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  slot_t         ex_q, ex_d;
  slot_t         mem_q, mem_d;

  logic src1_use;
  logic src2_use;
  logic lu;
  logic run;
  logic mem_req;
  logic freeze;
  logic redir;
  logic issue;

  assign src1_use = bus.alu_op1_type == `OP_TYPE_REG;
  assign src2_use = (bus.alu_op2_type == `OP_TYPE_REG)
                  | bus.is_store;

  assign lu = bus.id_valid & ex_q.v & ex_q.ld & ex_q.wen
            & (ex_q.dst != '0)
            & ((src1_use & (bus.src1_reg == ex_q.dst))
             | (src2_use & (bus.src2_reg == ex_q.dst)));

  assign run     = state_q == RUN;
  assign mem_req = mem_q.v & (mem_q.ld | mem_q.st);
  assign freeze  = mem_req & ~bus.mem_ready;
  // Redirects only matter in RUN; once draining nothing younger exists.
  assign redir   = bus.ex_redirect & ~freeze & run;
  assign issue   = run & bus.id_valid & ~freeze
                 & ~lu & ~bus.ex_redirect;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      unique case (state_q)
        RUN: begin
          if (issue & bus.is_halt) begin
            state_d = DRAIN;
            cnt_d   = CW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (cnt_q == '0) state_d = HALTED;
          else             cnt_d   = cnt_q - 1'b1;
        end
        HALTED: state_d = HALTED;
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!freeze) begin
      mem_d = ex_q;
      ex_d  = '0;
      // A halt retires through EX as a bubble.
      if (issue & ~bus.is_halt) begin
        ex_d.v   = 1'b1;
        ex_d.dst = bus.dst_reg;
        ex_d.wen = bus.reg_w_enable & (bus.dst_reg != '0);
        ex_d.ld  = bus.is_load;
        ex_d.st  = bus.is_store;
      end
    end
  end

  always_comb begin
    bus.if_stall    = 1'b0;
    bus.id_stall    = 1'b0;
    bus.ex_bubble   = 1'b0;
    bus.if_id_flush = 1'b0;
    priority case (1'b1)
      freeze: begin
        bus.if_stall = 1'b1;
        bus.id_stall = 1'b1;
      end
      !run: begin
        bus.if_stall  = 1'b1;
        bus.id_stall  = 1'b1;
        bus.ex_bubble = 1'b1;
      end
      redir: begin
        bus.if_id_flush = 1'b1;
        bus.ex_bubble   = 1'b1;
      end
      lu: begin
        bus.if_stall  = 1'b1;
        bus.id_stall  = 1'b1;
        bus.ex_bubble = 1'b1;
      end
      default: begin
        bus.if_stall = 1'b0;
      end
    endcase
  end

  assign bus.mem_freeze = freeze;
  assign bus.mem_req    = mem_req;
  assign bus.halted     = state_q == HALTED;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        stall_ev;

  assign stall_ev = ((lu & ~redir) | freeze) & run;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev)        stall_cnt_d = stall_cnt_q + 32'd1;
    if (bus.if_id_flush) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule
